// File: rtl/trena_tx_seq_if.sv
// Signal bundle between the trena sequencer and its neighbours: sensor interface,
// digit/ASCII mux and serial transmitter.
interface trena_tx_seq_if #(
    parameter int W_SEL = 3
);
    // Handshakes: the sequencer issues single-cycle requests (medir, partida_serial)
    // and waits, with no backpressure on the request, for the matching completion
    // level (pronto_medida, pronto_serial). A completion is only sampled while the
    // sequencer waits for it. sel_letra stays stable for the whole character.
    logic             mensurar;
    logic             modo_continuo;
    logic             parar;
    logic             pronto_medida;
    logic             pronto_serial;
    logic             medir;
    logic             partida_serial;
    logic [W_SEL-1:0] sel_letra;
    logic             pronto;
    logic             erro;
    logic             ocupado;

    modport master (
        input  mensurar, modo_continuo, parar, pronto_medida, pronto_serial,
        output medir, partida_serial, sel_letra, pronto, erro, ocupado
    );

    modport slave (
        output mensurar, modo_continuo, parar, pronto_medida, pronto_serial,
        input  medir, partida_serial, sel_letra, pronto, erro, ocupado
    );
endinterface

// File: rtl/trena_tx_seq.sv
// Trena sequencer: triggers a measurement, waits with timeout, then sends
// NUM_DIGITOS digits plus a terminator; single-shot or periodic operation.
module trena_tx_seq #(
    parameter int NUM_DIGITOS      = 3,
    parameter int W_SEL            = 3,
    parameter int TIMEOUT_CICLOS   = 1000,
    parameter int INTERVALO_CICLOS = 500,
    parameter int W_CONT           = 16
) (
    input  logic            clock,
    input  logic            reset,
    trena_tx_seq_if.master  bus,
    output logic [3:0]      db_estado
);
    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        DISPARA        = 4'd1,
        AGUARDA_MEDIDA = 4'd2,
        TRANSMITE      = 4'd3,
        ESPERA         = 4'd4,
        FINAL          = 4'd5,
        INTERVALO      = 4'd6,
        ERRO           = 4'd7
    } estado_t;

    localparam logic [W_SEL-1:0]  ULTIMO  = W_SEL'(NUM_DIGITOS);
    localparam logic [W_CONT-1:0] FIM_TMO = W_CONT'(TIMEOUT_CICLOS - 1);
    localparam logic [W_CONT-1:0] FIM_INT = W_CONT'(INTERVALO_CICLOS - 1);

    estado_t           estado, prox;
    logic [W_SEL-1:0]  idx, idx_d;
    logic [W_CONT-1:0] timer, timer_d, timer_inc;

    // Shared timer saturates so a stuck wait can never wrap into a false match.
    assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
            idx    <= '0;
            timer  <= '0;
        end else begin
            estado <= prox;
            idx    <= idx_d;
            timer  <= timer_d;
        end
    end

    always_comb begin
        prox               = estado;
        idx_d              = idx;
        timer_d            = timer;
        bus.medir          = 1'b0;
        bus.partida_serial = 1'b0;
        bus.sel_letra      = '0;
        bus.pronto         = 1'b0;
        bus.erro           = 1'b0;
        bus.ocupado        = (estado != INICIAL);
        db_estado          = estado;
        case (estado)
            INICIAL: begin
                if (bus.mensurar) prox = DISPARA;
            end
            DISPARA: begin
                bus.medir = 1'b1;
                idx_d     = '0;
                timer_d   = '0;
                prox      = AGUARDA_MEDIDA;
            end
            AGUARDA_MEDIDA: begin
                timer_d = timer_inc;
                // A result arriving on the last allowed cycle still wins.
                if (bus.pronto_medida)  prox = TRANSMITE;
                else if (timer == FIM_TMO) prox = ERRO;
            end
            TRANSMITE: begin
                bus.partida_serial = 1'b1;
                bus.sel_letra      = idx;
                prox               = ESPERA;
            end
            ESPERA: begin
                bus.sel_letra = idx;
                if (bus.pronto_serial) begin
                    if (idx == ULTIMO) begin
                        prox = FINAL;
                    end else begin
                        idx_d = idx + 1'b1;
                        prox  = TRANSMITE;
                    end
                end
            end
            FINAL: begin
                bus.pronto = 1'b1;
                if (bus.modo_continuo && !bus.parar) begin
                    timer_d = '0;
                    prox    = INTERVALO;
                end else begin
                    prox = INICIAL;
                end
            end
            INTERVALO: begin
                timer_d = timer_inc;
                if (bus.parar)              prox = INICIAL;
                else if (timer == FIM_INT)  prox = bus.modo_continuo ? DISPARA : INICIAL;
            end
            ERRO: begin
                bus.erro = 1'b1;
                prox     = INICIAL;
            end
            default: begin
                db_estado = 4'hE;
                prox      = INICIAL;
            end
        endcase
    end
endmodule
